// File: rtl/sub_result_seg_driver.sv
// Captures the substractor's signed 4-bit result and scans it as blank/sign/tens/units
// onto a common-anode 4-digit 7-segment display.
module sub_result_seg_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [3:0] result_i,
  input  logic       sign_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       loaded_o
);

  localparam int unsigned MAG_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    SEL_UNITS = 2'd0,
    SEL_TENS  = 2'd1,
    SEL_SIGN  = 2'd2,
    SEL_RSVD  = 2'd3
  } digit_sel_e;

  digit_sel_e       sel, sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [MAG_W-1:0] mag, mag_nxt;
  logic             neg, neg_nxt;
  logic             loaded_nxt;
  logic [3:0]       an_nxt;
  logic [SEG_W-1:0] seg_nxt;
  logic             wrap_c;
  logic             tens_c;
  logic [MAG_W-1:0] units_c;

  // Active-low decimal digit glyphs, {g,f,e,d,c,b,a}
  function automatic logic [SEG_W-1:0] digit_glyph(input logic [MAG_W-1:0] d);
    logic [SEG_W-1:0] g;
    g = GLYPH_BLANK;
    case (d)
      4'd0: g = 7'b1000000;
      4'd1: g = 7'b1111001;
      4'd2: g = 7'b0100100;
      4'd3: g = 7'b0110000;
      4'd4: g = 7'b0011001;
      4'd5: g = 7'b0010010;
      4'd6: g = 7'b0000010;
      4'd7: g = 7'b1111000;
      4'd8: g = 7'b0000000;
      4'd9: g = 7'b0010000;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= SEL_UNITS;
      cnt      <= '0;
      mag      <= '0;
      neg      <= 1'b0;
      loaded_o <= 1'b0;
      an_o     <= 4'b1111;
      seg_o    <= GLYPH_BLANK;
    end else begin
      sel      <= sel_nxt;
      cnt      <= cnt_nxt;
      mag      <= mag_nxt;
      neg      <= neg_nxt;
      loaded_o <= loaded_nxt;
      an_o     <= an_nxt;
      seg_o    <= seg_nxt;
    end
  end

  // Next-state: refresh timing, digit scan, capture, and the registered display image
  always_comb begin
    cnt_nxt    = cnt + CNT_W'(1);
    sel_nxt    = sel;
    mag_nxt    = mag;
    neg_nxt    = neg;
    loaded_nxt = loaded_o;
    an_nxt     = 4'b1111;
    seg_nxt    = GLYPH_BLANK;

    wrap_c  = (cnt == CNT_W'(REFRESH_DIV - 1));
    tens_c  = (mag >= MAG_W'(10));
    units_c = tens_c ? (mag - MAG_W'(10)) : mag;

    if (wrap_c) begin
      cnt_nxt = '0;
      case (sel)
        SEL_UNITS: sel_nxt = SEL_TENS;
        SEL_TENS:  sel_nxt = SEL_SIGN;
        default:   sel_nxt = SEL_UNITS;
      endcase
    end

    // Zero magnitude never keeps a sign, so "-0" cannot be shown
    if (valid_i) begin
      mag_nxt    = result_i;
      neg_nxt    = sign_i && (result_i != '0);
      loaded_nxt = 1'b1;
    end

    case (sel)
      SEL_UNITS: begin
        an_nxt  = 4'b1110;
        seg_nxt = digit_glyph(units_c);
      end
      SEL_TENS: begin
        an_nxt  = 4'b1101;
        seg_nxt = tens_c ? digit_glyph(MAG_W'(1)) : GLYPH_BLANK;
      end
      SEL_SIGN: begin
        an_nxt  = 4'b1011;
        seg_nxt = neg ? GLYPH_MINUS : GLYPH_BLANK;
      end
      default: begin
        an_nxt  = 4'b1111;
        seg_nxt = GLYPH_BLANK;
      end
    endcase

    if (!loaded_o) begin
      seg_nxt = GLYPH_BLANK;
    end
  end

endmodule

// File: tb/tb_sub_result_seg_driver.sv
// Directed bench for sub_result_seg_driver with REFRESH_DIV=4; the displayed slot after
// edge e (counted from reset release) is ((e-1)/4) mod 3.
module tb_sub_result_seg_driver;

  logic       clk;
  logic       rst_n;
  logic       valid_i;
  logic [3:0] result_i;
  logic       sign_i;
  logic [3:0] an_o;
  logic [6:0] seg_o;
  logic       loaded_o;

  int n_tests;
  int n_fail;
  int e;

  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_MINUS = 7'b0111111;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;

  sub_result_seg_driver #(.REFRESH_DIV(4), .CNT_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .result_i (result_i),
    .sign_i   (sign_i),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .loaded_o (loaded_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic goto(input int target);
    while (e < target) tick();
  endtask

  task automatic capture(input logic [3:0] r, input logic s);
    valid_i  = 1'b1;
    result_i = r;
    sign_i   = s;
    tick();
    valid_i  = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    e        = 0;
    rst_n    = 1'b0;
    valid_i  = 1'b0;
    result_i = 4'd0;
    sign_i   = 1'b0;

    // Reset held while clocking
    repeat (3) tick();
    check("rst_an", 7'(an_o), 7'(4'b1111));
    check("rst_seg", seg_o, G_BLANK);
    check("rst_loaded", 7'(loaded_o), 7'd0);

    rst_n = 1'b1;
    e = 0;

    // Unloaded scan: anodes cycle, segments stay blank
    goto(1);
    check("scan0_an", 7'(an_o), 7'(4'b1110));
    check("scan0_seg", seg_o, G_BLANK);
    goto(4);
    check("scan0_hold_an", 7'(an_o), 7'(4'b1110));
    goto(5);
    check("scan1_an", 7'(an_o), 7'(4'b1101));
    check("scan1_seg", seg_o, G_BLANK);
    goto(9);
    check("scan2_an", 7'(an_o), 7'(4'b1011));
    check("scan2_seg", seg_o, G_BLANK);

    // Positive 4
    capture(4'd4, 1'b0);
    check("pos_loaded", 7'(loaded_o), 7'd1);
    goto(13);
    check("pos_units_an", 7'(an_o), 7'(4'b1110));
    check("pos_units", seg_o, G4);
    goto(17);
    check("pos_tens", seg_o, G_BLANK);
    goto(21);
    check("pos_sign", seg_o, G_BLANK);

    // Negative 10
    capture(4'd10, 1'b1);
    goto(25);
    check("neg10_units", seg_o, G0);
    goto(29);
    check("neg10_tens", seg_o, G1);
    goto(33);
    check("neg10_sign_an", 7'(an_o), 7'(4'b1011));
    check("neg10_sign", seg_o, G_MINUS);

    // Zero with spurious sign
    capture(4'd0, 1'b1);
    goto(37);
    check("zero_units", seg_o, G0);
    goto(41);
    check("zero_tens", seg_o, G_BLANK);
    goto(45);
    check("zero_sign", seg_o, G_BLANK);

    // Mid-scan update: 15/neg then 3/pos while tens slot is lit
    capture(4'd15, 1'b1);
    goto(49);
    check("m15_units", seg_o, G5);
    goto(53);
    check("m15_tens", seg_o, G1);
    capture(4'd3, 1'b0);
    check("mid_edge_tens", seg_o, G1);
    tick();
    check("mid_tens_an", 7'(an_o), 7'(4'b1101));
    check("mid_tens_seg", seg_o, G_BLANK);
    goto(56);
    check("mid_phase_hold", 7'(an_o), 7'(4'b1101));
    goto(57);
    check("mid_phase_sign_an", 7'(an_o), 7'(4'b1011));
    check("mid_sign", seg_o, G_BLANK);
    goto(61);
    check("p3_units", seg_o, G3);

    // Back-to-back captures: last wins
    capture(4'd7, 1'b0);
    capture(4'd12, 1'b1);
    goto(65);
    check("b2b_tens", seg_o, G1);
    goto(69);
    check("b2b_sign", seg_o, G_MINUS);
    goto(73);
    check("b2b_units", seg_o, G2);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_an", 7'(an_o), 7'(4'b1111));
    check("arst_seg", seg_o, G_BLANK);
    check("arst_loaded", 7'(loaded_o), 7'd0);
    tick();
    tick();
    rst_n = 1'b1;
    e = 0;
    goto(1);
    check("post_an", 7'(an_o), 7'(4'b1110));
    check("post_seg", seg_o, G_BLANK);
    check("post_loaded", 7'(loaded_o), 7'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_result_seg_driver.md
Name: sub_result_seg_driver

Overview:
- Downstream consumer of the 4-bit substractor's `result`/`sign` pair.
- Captures a result on a valid strobe and holds it in a register.
- Renders the held result as a signed decimal on a 4-digit, time-multiplexed, common-anode 7-segment display: blank, sign, tens, units.
- Sits between the combinational substractor and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit (minimum 2).
- CNT_W, 16, refresh counter width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid_i  input  1  single-cycle strobe; capture result_i/sign_i this edge.
- result_i  input  4  magnitude of the difference from the substractor (0..15).
- sign_i  input  1  1 = negative difference.
- an_o  output  4  digit anodes, active-low; an_o[3] leftmost.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
- loaded_o  output  1  1 once any value has been captured since reset.

Behaviour:
- Reset (asynchronous, rst_n=0), all held until release:
  - an_o=4'b1111, seg_o=7'b1111111, loaded_o=0.
  - Refresh counter=0, digit select=0, held magnitude=0, held sign=0.
- Capture:
  - On a rising edge with valid_i=1, latch result_i and sign_i and set loaded_o=1 on the same edge.
  - A capture never disturbs the refresh counter or the digit select.
  - Back-to-back valid_i pulses: the last one wins, with no lost cycles.
- Sign normalisation: if result_i=0, the held sign is 0 regardless of sign_i (no "-0").
- Decimal split, combinational from the held magnitude:
  - tens = 1 if magnitude >= 10, else 0.
  - units = magnitude - 10*tens.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit select advances 0 (units) -> 1 (tens) -> 2 (sign) -> 0.
  - Digit select value 3 is never entered; if it is somehow reached, it goes to 0 on the next wrap.
- Output stage, registered, one clock of latency from a digit-select or held-value change:
  - Select 0: an_o=4'b1110, seg_o=units glyph.
  - Select 1: an_o=4'b1101, seg_o=tens glyph when tens=1, blank when tens=0 (leading-zero blanking).
  - Select 2: an_o=4'b1011, seg_o=minus when held sign=1, blank otherwise.
  - an_o[3] is always 1.
  - While loaded_o=0, an_o keeps scanning but seg_o stays 7'b1111111.
- Glyphs, seg_o {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - minus=0111111, blank=1111111.
- Exactly one anode is low at any time after the first registered update; no two anodes are ever low together.
- Reset mid-scan: outputs go blank immediately (asynchronously); after release, scanning restarts at select 0 with loaded_o=0.

Test Plan (REFRESH_DIV=4):
- Reset:
  - Stimulus: hold rst_n=0, toggle clk.
  - Required response: an_o=1111, seg_o=1111111, loaded_o=0.
  - After release, with no valid_i: an_o cycles 1110 -> 1101 -> 1011 at 4-cycle spacing, seg_o stays blank.
- Positive result:
  - Stimulus: valid_i pulse with result_i=4, sign_i=0 (10-6).
  - Required response: loaded_o=1 on the capture edge.
  - Units slot: seg_o=0011001.
  - Tens slot and sign slot: blank.
- Negative two-digit result:
  - Stimulus: result_i=10, sign_i=1 (2-12).
  - Required response: units slot 1000000, tens slot 1111001, sign slot 0111111.
- Zero:
  - Stimulus: result_i=0 with sign_i=1 (10-10 with a spurious sign).
  - Required response: units slot 1000000, sign slot blank (normalised).
- Mid-scan update:
  - Stimulus: capture 15/neg, then capture 3/pos while the tens slot is lit.
  - Required response: the next registered seg_o in the tens slot is blank; the counter phase is unchanged.
- Async reset mid-scan:
  - Stimulus: assert rst_n between clock edges while the display is lit.
  - Required response: an_o=1111 and seg_o blank immediately, before the next clock edge; loaded_o=0.
